// File: rtl/ipgu_pkg.sv
// Shared definitions for the IPGU frame-level logic.
//   ipgu_state_e   : frame sequencer states (IDLE, LOAD, START, RUN, DONE)
//   WIN_DIM        : window edge in pixels
//   level_windows(): windows per edge at each scale level {15,12,9,6,3,1}
//   IMG_DIM        : frame edge in pixels (level-0 windows x WIN_DIM)
//   TOTAL_WINDOWS  : windows handed to the HEU per frame, all levels
//   TIMEOUT_CYCLES : default watchdog limit, used only when the
//                    IPGU_FRAME_TIMEOUT_EN build option is defined
package ipgu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } ipgu_state_e;

  localparam int WIN_DIM    = 20;
  localparam int NUM_LEVELS = 6;

  // Windows along one edge of the pyramid at scale level lvl.
  function automatic int level_windows(input int lvl);
    case (lvl)
      0:       return 15;
      1:       return 12;
      2:       return 9;
      3:       return 6;
      4:       return 3;
      default: return 1;
    endcase
  endfunction

  // Each level is square, so its window count is the edge count squared.
  function automatic int total_windows();
    int sum;
    sum = 0;
    for (int lvl = 0; lvl < NUM_LEVELS; lvl++) begin
      sum += level_windows(lvl) * level_windows(lvl);
    end
    return sum;
  endfunction

  localparam int IMG_DIM        = level_windows(0) * WIN_DIM;  // 300
  localparam int TOTAL_WINDOWS  = total_windows();             // 496
  localparam int TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/ipgu_raster_addr_gen.sv
// Raster x/y position counter for loading a square image into RAM.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart at (0,0); takes priority over step
//   step     : advance one pixel in raster order
//   x, y     : current pixel position (9-bit unsigned)
//   last     : current position is the final pixel (DIM-1, DIM-1)
module ipgu_raster_addr_gen
  import ipgu_pkg::*;
#(
  parameter int DIM = IMG_DIM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       last
);

  localparam logic [8:0] EDGE_LAST = 9'(DIM - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == EDGE_LAST) begin
        x <= '0;
        // Wrapping y after the last pixel leaves the counter ready at (0,0).
        y <= (y == EDGE_LAST) ? '0 : y + 9'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

  assign last = (x == EDGE_LAST) && (y == EDGE_LAST);

endmodule

// File: rtl/ipgu_frame_ctrl.sv
// Frame-level sequencer for the IPGU pyramid generator.
// Loads one greyscale frame from a pixel stream into RAM1, pulses initIpgu,
// counts the windows IPGU hands to the HEU, and reports frame completion.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : frame request level, sampled only in IDLE
//   pix_vld/pix_data/pix_rdy : input pixel stream
//   csRam1_ext, weRam1_ext, addrRam1_ext ({y,x}), wrDataRam1_ext : RAM1 write port
//   initIpgu        : one-cycle IPGU start pulse
//   vldIpgu, rdyHeu : IPGU->HEU window handshake, monitored only
//   busy            : frame in progress
//   frame_done      : one-cycle completion pulse
//   win_cnt         : windows consumed this frame (holds until next start)
//   err             : one-cycle pulse on start-while-busy (or watchdog expiry)
//
// Handshakes: a pixel is accepted on a rising clk edge where pix_vld and
// pix_rdy are both high; a window is counted on a rising edge in RUN where
// vldIpgu and rdyHeu are both high. pix_vld may be held with no obligation
// on pix_rdy; pix_rdy is combinational from state only.
//
// Build option IPGU_FRAME_TIMEOUT_EN: adds a 16-bit watchdog that aborts RUN
// after TIMEOUT_CYCLES consecutive cycles without a handshake (err pulse,
// no frame_done). Without it RUN waits indefinitely.
module ipgu_frame_ctrl #(
  parameter int IMG_DIM        = ipgu_pkg::IMG_DIM,
  parameter int TOTAL_WINDOWS  = ipgu_pkg::TOTAL_WINDOWS
`ifdef IPGU_FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = ipgu_pkg::TIMEOUT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_vld,
  input  logic [7:0]  pix_data,
  output logic        pix_rdy,
  output logic        csRam1_ext,
  output logic        weRam1_ext,
  output logic [17:0] addrRam1_ext,
  output logic [7:0]  wrDataRam1_ext,
  output logic        initIpgu,
  input  logic        vldIpgu,
  input  logic        rdyHeu,
  output logic        busy,
  output logic        frame_done,
  output logic [8:0]  win_cnt,
  output logic        err
);

  import ipgu_pkg::*;

  localparam logic [8:0] WIN_TOTAL = 9'(TOTAL_WINDOWS);
  localparam logic [8:0] WIN_LAST  = 9'(TOTAL_WINDOWS - 1);

  ipgu_state_e state, next_state;

  logic [8:0] pos_x, pos_y;
  logic       pos_last;
  logic       accept;
  logic       win_hs;
  logic       timeout;
  logic       frame_go;

  logic       busy_nxt;
  logic       init_nxt;
  logic       done_nxt;
  logic       err_nxt;
  logic [8:0] win_cnt_nxt;

  // The state leaves LOAD on the edge that accepts the last pixel, so
  // "in LOAD" already implies the last pixel has not been taken yet.
  assign pix_rdy  = (state == LOAD);
  assign accept   = pix_vld && pix_rdy;
  assign win_hs   = (state == RUN) && vldIpgu && rdyHeu;
  assign frame_go = (state == IDLE) && start;

  ipgu_raster_addr_gen #(
    .DIM (IMG_DIM)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (frame_go),
    .step  (accept),
    .x     (pos_x),
    .y     (pos_y),
    .last  (pos_last)
  );

`ifdef IPGU_FRAME_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;

  // wd_cnt holds the number of idle RUN cycles already seen, so the
  // TIMEOUT_CYCLES-th idle cycle is the one where it equals WD_LAST.
  assign timeout = (state == RUN) && !win_hs && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state != RUN) || win_hs) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and next-output logic; every output below is registered.
  always_comb begin
    next_state  = state;
    win_cnt_nxt = win_cnt;

    case (state)
      IDLE:  if (start) next_state = LOAD;
      LOAD:  if (accept && pos_last) next_state = START;
      START: next_state = RUN;
      RUN: begin
        if (timeout) begin
          next_state = DONE;
        end else if (win_hs && (win_cnt == WIN_LAST)) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (frame_go) begin
      win_cnt_nxt = '0;
    end else if (win_hs && (win_cnt != WIN_TOTAL)) begin
      win_cnt_nxt = win_cnt + 9'd1;
    end

    busy_nxt = (next_state == LOAD) || (next_state == START) || (next_state == RUN);
    // START is the cycle the final write is on the bus; IPGU starts after it.
    init_nxt = (state == START);
    done_nxt = (state == RUN) && (next_state == DONE) && !timeout;
    // DONE is not busy, so a start arriving with frame_done is silently ignored.
    err_nxt  = (start && ((state == LOAD) || (state == START) || (state == RUN))) || timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      csRam1_ext     <= 1'b0;
      weRam1_ext     <= 1'b0;
      addrRam1_ext   <= '0;
      wrDataRam1_ext <= '0;
      initIpgu       <= 1'b0;
      frame_done     <= 1'b0;
      win_cnt        <= '0;
      err            <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= busy_nxt;
      // Chip select is only ever driven for a write, so IPGU owns RAM1 otherwise.
      csRam1_ext <= accept;
      weRam1_ext <= accept;
      if (accept) begin
        addrRam1_ext   <= {pos_y, pos_x};
        wrDataRam1_ext <= pix_data;
      end
      initIpgu   <= init_nxt;
      frame_done <= done_nxt;
      win_cnt    <= win_cnt_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ipgu_frame_ctrl.sv
// Self-checking bench for ipgu_frame_ctrl, run with a reduced frame edge.
// Reference model: pixel n of a frame lands at {n / edge, n % edge}; windows
// are counted as plain handshake totals; cycle-level expectations follow the
// documented latencies (write 1 cycle after accept, initIpgu 2 cycles after
// the last accept, frame_done/busy-fall 1 cycle after the final handshake).
module tb_ipgu_frame_ctrl;

  localparam int BIMG = 30;
  localparam int NPIX = BIMG * BIMG;
  localparam int TW   = 496;
  localparam int TO   = 100;
  localparam int W    = 26;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pix_vld;
  logic [7:0]  pix_data;
  logic        pix_rdy;
  logic        csRam1_ext;
  logic        weRam1_ext;
  logic [17:0] addrRam1_ext;
  logic [7:0]  wrDataRam1_ext;
  logic        initIpgu;
  logic        vldIpgu;
  logic        rdyHeu;
  logic        busy;
  logic        frame_done;
  logic [8:0]  win_cnt;
  logic        err;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_miscmp;

  ipgu_frame_ctrl #(
    .IMG_DIM        (BIMG),
    .TOTAL_WINDOWS  (TW)
`ifdef IPGU_FRAME_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pix_vld        (pix_vld),
    .pix_data       (pix_data),
    .pix_rdy        (pix_rdy),
    .csRam1_ext     (csRam1_ext),
    .weRam1_ext     (weRam1_ext),
    .addrRam1_ext   (addrRam1_ext),
    .wrDataRam1_ext (wrDataRam1_ext),
    .initIpgu       (initIpgu),
    .vldIpgu        (vldIpgu),
    .rdyHeu         (rdyHeu),
    .busy           (busy),
    .frame_done     (frame_done),
    .win_cnt        (win_cnt),
    .err            (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] addr_of(input int n);
    int yy;
    int xx;
    yy = n / BIMG;
    xx = n % BIMG;
    return 18'(yy * 512 + xx);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_rdy"},   pix_rdy, 0);
    check({tag, "_cs"},    csRam1_ext, 0);
    check({tag, "_we"},    weRam1_ext, 0);
    check({tag, "_addr"},  addrRam1_ext, 0);
    check({tag, "_wdata"}, wrDataRam1_ext, 0);
    check({tag, "_init"},  initIpgu, 0);
    check({tag, "_done"},  frame_done, 0);
    check({tag, "_wcnt"},  win_cnt, 0);
    check({tag, "_err"},   err, 0);
  endtask

  // Driver: start a frame from IDLE and stream it in.
  // mode 1: pix_vld always 1, mode 2: every other cycle, else random.
  // abort_at > 0 returns after that many accepts have been scheduled.
  task automatic load_frame(input int mode, input int abort_at);
    int n_acc;
    int cyc;
    bit prev_acc;
    bit exp_err;
    bit fin;
    bit v;
    logic [W-1:0] w;
    exp_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ld_wcnt_clr", win_cnt, 0);
    n_acc = 0; cyc = 0; prev_acc = 0; exp_err = 0; fin = 0;
    while (!fin) begin
      check("ld_cs", csRam1_ext, prev_acc);
      check("ld_we", weRam1_ext, prev_acc);
      if (prev_acc) begin
        w = exp_q.pop_front();
        check("ld_addr", addrRam1_ext, w[25:8]);
        check("ld_wdata", wrDataRam1_ext, w[7:0]);
      end
      check("ld_rdy", pix_rdy, n_acc < NPIX);
      check("ld_err", err, exp_err);
      check("ld_init", initIpgu, 0);
      check("ld_busy", busy, 1);
      check("ld_done", frame_done, 0);
      fin = (n_acc == NPIX);
      case (mode)
        1:       v = 1'b1;
        2:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      pix_vld  = v;
      pix_data = 8'($urandom);
      start    = !fin && (n_acc > 0) && ($urandom_range(0, 199) == 0);
      exp_err  = start;
      prev_acc = v && (n_acc < NPIX);
      if (prev_acc) begin
        exp_q.push_back({addr_of(n_acc), pix_data});
        n_acc++;
      end
      cyc++;
      if (abort_at > 0 && n_acc == abort_at) begin
        pix_vld = 1'b0;
        start   = 1'b0;
        return;
      end
      @(negedge clk);
      if (cyc > 4 * NPIX + 8) begin
        check("ld_bound", n_acc, NPIX + 1);
        fin = 1;
      end
    end
    // First RUN cycle: IPGU start pulse, RAM released.
    check("st_init", initIpgu, 1);
    check("st_cs", csRam1_ext, 0);
    check("st_we", weRam1_ext, 0);
    check("st_rdy", pix_rdy, 0);
    check("st_busy", busy, 1);
    check("st_err", err, 0);
    check("st_left", exp_q.size(), 0);
  endtask

  // Driver: window handshakes with random gaps until the frame completes.
  task automatic run_windows();
    int cnt;
    int it;
    bit exp_err;
    cnt = 0; it = 0; exp_err = 0;
    while (cnt < TW && it < 20000) begin
      check("rn_wcnt", win_cnt, cnt);
      check("rn_busy", busy, 1);
      check("rn_done", frame_done, 0);
      check("rn_err", err, exp_err);
      check("rn_cs", csRam1_ext, 0);
      check("rn_init", initIpgu, it == 0);
      vldIpgu = $urandom_range(0, 3) != 0;
      rdyHeu  = $urandom_range(0, 2) != 0;
      pix_vld = 1'($urandom_range(0, 1));
      start   = $urandom_range(0, 99) == 0;
      exp_err = start;
      if (vldIpgu && rdyHeu) cnt++;
      it++;
      @(negedge clk);
    end
    check("rn_bound", cnt, TW);
    check("dn_done", frame_done, 1);
    check("dn_busy", busy, 0);
    check("dn_wcnt", win_cnt, TW);
    check("dn_err", err, exp_err);
    check("dn_rdy", pix_rdy, 0);
    // start in the DONE cycle is ignored; extra handshakes do not count.
    start = 1'b1; vldIpgu = 1'b1; rdyHeu = 1'b1;
    @(negedge clk);
    check("id_done", frame_done, 0);
    check("id_busy", busy, 0);
    check("id_err", err, 0);
    check("id_wcnt", win_cnt, TW);
    start = 1'b0; vldIpgu = 1'b0; rdyHeu = 1'b0; pix_vld = 1'b0;
    @(negedge clk);
    check("id2_busy", busy, 0);
    check("id2_rdy", pix_rdy, 0);
    check("id2_wcnt", win_cnt, TW);
    check("id2_cs", csRam1_ext, 0);
  endtask

`ifdef IPGU_FRAME_TIMEOUT_EN
  task automatic run_timeout();
    for (int i = 0; i < 10; i++) begin
      check("to_wcnt_hs", win_cnt, i);
      vldIpgu = 1'b1; rdyHeu = 1'b1;
      @(negedge clk);
    end
    for (int k = 1; k <= TO; k++) begin
      check("to_wcnt", win_cnt, 10);
      check("to_err_early", err, 0);
      check("to_busy", busy, 1);
      vldIpgu = 1'b1; rdyHeu = 1'b0;
      @(negedge clk);
    end
    check("to_err", err, 1);
    check("to_done", frame_done, 0);
    check("to_busy_fall", busy, 0);
    check("to_wcnt_end", win_cnt, 10);
    vldIpgu = 1'b0;
    @(negedge clk);
    check("to_err_once", err, 0);
    check("to_done_none", frame_done, 0);
    check("to_idle", busy, 0);
  endtask
`endif

  initial begin
    n_vec = 0; n_miscmp = 0;
    rst = 1'b1; start = 1'b0; pix_vld = 1'b0; pix_data = 8'h00;
    vldIpgu = 1'b0; rdyHeu = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    rst = 1'b0;
    pix_vld = 1'b1;
    @(negedge clk);
    check_idle("idle_vld");
    pix_vld = 1'b0;

    // Abandon a frame part-way through loading.
    load_frame(3, NPIX / 3);
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_after");

    load_frame(1, 0);
    run_windows();
    load_frame(2, 0);
    run_windows();
    load_frame(3, 0);
    run_windows();
`ifdef IPGU_FRAME_TIMEOUT_EN
    load_frame(1, 0);
    run_timeout();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/ipgu_frame_ctrl.md
Name: ipgu_frame_ctrl

Overview:
Frame-level sequencer for the IPGU pyramid generator.
- Accepts one 8-bit greyscale frame as a raster pixel stream and writes it into IPGU RAM1 through the external port.
- Pulses initIpgu, then counts the 20x20 windows handed from IPGU to the HEU across all six scale levels.
- Reports frame completion to the control unit. Sits between the control unit/DMA and ipgu.

Parameters:
- RAM_DATA_WIDTH, 8, pixel width.
- RAM_ADDR_WIDTH, 18, RAM1 address width, {y[8:0], x[8:0]}.
- IMG_DIM, 300, frame edge in pixels (15 windows x 20).
- TOTAL_WINDOWS, 496, windows per frame (225+144+81+36+9+1).
- TIMEOUT_CYCLES, 65535, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  frame start request (level, sampled in IDLE)
- pix_vld  in  1  stream pixel valid
- pix_data  in  8  stream pixel
- pix_rdy  out  1  stream ready
- csRam1_ext  out  1  RAM1 external chip select
- weRam1_ext  out  1  RAM1 external write enable
- addrRam1_ext  out  18  RAM1 address {y,x}
- wrDataRam1_ext  out  8  RAM1 write data
- initIpgu  out  1  one-cycle IPGU start pulse
- vldIpgu  in  1  IPGU window valid (monitored)
- rdyHeu  in  1  HEU ready (monitored)
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle completion pulse
- win_cnt  out  9  windows consumed this frame
- err  out  1  one-cycle pulse: start while busy, or timeout

Behaviour:
Reset and common rules:
- Clock is clk. Reset is asynchronous and active-high.
- Reset forces IDLE with every output 0, the x/y/win counters 0 and the write register cleared.
- Reset mid-frame abandons the frame; no frame_done is generated.
- All outputs except pix_rdy are registered. pix_rdy = (state==LOAD) && !last_accepted.

States: IDLE, LOAD, START, RUN, DONE.
- IDLE: busy=0. On start=1, go to LOAD, clear x, y and win_cnt, set busy=1.
- LOAD: pix_rdy=1. Each accept (pix_vld && pix_rdy) registers a write; next cycle csRam1_ext=weRam1_ext=1, addrRam1_ext={y,x}, wrDataRam1_ext=pixel.
  - Write latency is exactly 1 cycle from accept.
  - With no accept, cs and we are 0 the next cycle.
  - x increments 0..IMG_DIM-1. On wrap, x goes to 0 and y increments.
  - On accepting pixel (IMG_DIM-1, IMG_DIM-1), pix_rdy drops the next cycle and the state goes to START.
- START: the final write is issued this cycle. Next cycle initIpgu=1 for exactly one cycle, csRam1_ext=0, then RUN.
  - csRam1_ext is 0 in every state except the write cycles, so IPGU owns RAM1 internally.
- RUN: win_cnt increments on each cycle with vldIpgu && rdyHeu.
  - The handshake taking win_cnt to TOTAL_WINDOWS goes to DONE.
  - win_cnt saturates at TOTAL_WINDOWS.
- DONE: frame_done=1 for one cycle, busy=0, back to IDLE. win_cnt holds until the next start.

Boundary and error rules:
- start while busy is ignored and pulses err for one cycle.
- start asserted in the same cycle as frame_done (DONE) is ignored with no err; it is re-sampled in IDLE the next cycle.
- pix_vld outside LOAD is dropped (pix_rdy=0) with no side effect.
- Width rules: x and y are 9-bit unsigned, win_cnt is 9-bit unsigned, no overflow (496 < 512). Address = {y, x} concatenation, not multiplied.

Optional Feature:
IPGU_FRAME_TIMEOUT_EN
- Defined: a 16-bit watchdog counts RUN cycles with no handshake and clears on each handshake.
  - Reaching TIMEOUT_CYCLES pulses err and forces DONE without frame_done; state returns to IDLE.
- Undefined: no watchdog logic. RUN waits indefinitely and err reports only start-while-busy.

Decomposition:
- Shared package ipgu_pkg: state enum type (IDLE, LOAD, START, RUN, DONE), IMG_DIM, WIN_DIM=20, TOTAL_WINDOWS, and the per-level window-count constants {15,12,9,6,3,1}.
- One sub-module is natural: ipgu_raster_addr_gen (x/y counter with wrap and last flag), reusable by other RAM loaders.

Test Plan:
1. Reset mid-LOAD after 1000 pixels -> all outputs 0, state IDLE; next start reloads from addr {0,0}.
2. start, stream 90000 pixels with pix_vld=1 continuously -> writes to {0,0}..{299,299} each 1 cycle after accept; initIpgu single pulse 2 cycles after last accept; pix_rdy=0 after last.
3. Stream with pix_vld toggling every other cycle -> exactly 90000 writes, no duplicates, correct raster order; cs and we low on idle cycles.
4. Model 496 handshakes with random rdyHeu gaps -> win_cnt=496, one frame_done pulse, busy falls the same cycle; vldIpgu with rdyHeu=0 does not count.
5. start pulsed during LOAD and RUN -> err pulses once each, frame unaffected.
6. With IPGU_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100: stall after 10 handshakes -> err at the 100th idle cycle, no frame_done, state IDLE.
